// File: rtl/cpu_run_ctrl_pkg.sv
// rtl/cpu_run_ctrl_pkg.sv - shared types and constants for the CPU run controller
package cpu_run_ctrl_pkg;

    localparam int CNT_W = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_PAUSE = 3'd1,
        S_RUN   = 3'd2,
        S_STEP  = 3'd3,
        S_HALT  = 3'd4
    } run_state_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, stable-sample debouncer and press pulse
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]    sync_q;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    // Count consecutive synchronized samples that differ from the accepted level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DW'(DEB_CYCLES - 1)) begin
            cnt_d   = '0;
            level_d = sync_q[1];
            press_d = sync_q[1];
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/pause/step/halt sequencer issuing cpu_en pulses
// Optional breakpoint support: CPU_RUN_CTRL_BREAKPOINT_EN
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 1000000,
    parameter int DEB_CYCLES = 1000000,
    parameter int RST_HOLD   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             btn_cpu_rst,
    input  logic             halt_req,
    input  logic [31:0]      pc,
    input  logic [15:0]      bp_addr,
    input  logic             bp_valid,
    output logic             cpu_en,
    output logic             cpu_rst,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    logic run_p, step_p, rst_p;
    logic run_level_unused, step_level_unused, rst_level_unused;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clk(clk), .reset_n(reset_n), .raw(btn_run),
        .level(run_level_unused), .press(run_p)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk(clk), .reset_n(reset_n), .raw(btn_step),
        .level(step_level_unused), .press(step_p)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
        .clk(clk), .reset_n(reset_n), .raw(btn_cpu_rst),
        .level(rst_level_unused), .press(rst_p)
    );

    run_state_e       state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic              en_q, en_d;
    logic              tick_fire;
    logic              bp_hit;

    assign tick_fire = (tick_q == TICK_W'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        tick_d  = '0;
        en_d    = 1'b0;
        cyc_d   = cyc_q;
        if (rst_p) begin
            state_d = S_RESET;
            hold_d  = '0;
            cyc_d   = '0;
        end else begin
            case (state_q)
                S_RESET: begin
                    if (hold_q == HOLD_W'(RST_HOLD - 1)) state_d = S_PAUSE;
                    else                                 hold_d  = hold_q + 1'b1;
                end
                S_PAUSE: begin
                    if (halt_req)    state_d = S_HALT;
                    else if (run_p)  state_d = S_RUN;
                    else if (step_p) state_d = S_STEP;
                end
                S_RUN: begin
                    if (halt_req) begin
                        state_d = S_HALT;
                    end else if (run_p) begin
                        state_d = S_PAUSE;
                    end else begin
                        tick_d = tick_fire ? '0 : tick_q + 1'b1;
                        if (tick_fire) begin
                            if (bp_hit) state_d = S_PAUSE;
                            else        en_d    = 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    if (halt_req) begin
                        state_d = S_HALT;
                    end else begin
                        en_d    = 1'b1;
                        state_d = S_PAUSE;
                    end
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_RESET;
            endcase
            if (en_d && cyc_q != CNT_MAX) cyc_d = cyc_q + 1'b1;
        end
    end

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    // skip_bp lets the instruction sitting on the breakpoint retire after a resume.
    logic skip_bp_q, skip_bp_d;
    logic unused_pc_hi;

    assign unused_pc_hi = ^pc[31:16];
    assign bp_hit = bp_valid && (pc[15:0] == bp_addr) && !skip_bp_q;

    always_comb begin
        skip_bp_d = skip_bp_q;
        if (rst_p)
            skip_bp_d = 1'b0;
        else if (state_q == S_PAUSE && (state_d == S_RUN || state_d == S_STEP))
            skip_bp_d = 1'b1;
        else if (en_d)
            skip_bp_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) skip_bp_q <= 1'b0;
        else          skip_bp_q <= skip_bp_d;
    end
`else
    logic unused_bp;

    assign unused_bp = ^{pc, bp_addr, bp_valid};
    assign bp_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RESET;
            hold_q  <= '0;
            tick_q  <= '0;
            cyc_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            tick_q  <= tick_d;
            cyc_q   <= cyc_d;
            en_q    <= en_d;
        end
    end

    assign cpu_en      = en_q;
    assign cpu_rst     = (state_q == S_RESET);
    assign state_o     = state_q;
    assign cycle_count = cyc_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        btn_run, btn_step, btn_cpu_rst, halt_req;
    logic [31:0] pc;
    logic [15:0] bp_addr;
    logic        bp_valid;
    logic        cpu_en, cpu_rst;
    logic [2:0]  state_o;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.TICK_DIV(4), .DEB_CYCLES(3), .RST_HOLD(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .btn_run(btn_run), .btn_step(btn_step), .btn_cpu_rst(btn_cpu_rst),
        .halt_req(halt_req), .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
        .cpu_en(cpu_en), .cpu_rst(cpu_rst), .state_o(state_o), .cycle_count(cycle_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; btn_run = 1'b0; btn_step = 1'b0; btn_cpu_rst = 1'b0;
        halt_req = 1'b0; pc = 32'h0; bp_addr = 16'h0; bp_valid = 1'b0;

        cyc(2);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_count", cycle_count, 32'd0);

        reset_n = 1'b1;
        check("hold0_cpu_rst", 32'(cpu_rst), 32'd1);
        cyc(1);
        check("hold1_state", 32'(state_o), 32'd0);
        check("hold1_cpu_rst", 32'(cpu_rst), 32'd1);
        cyc(1);
        check("pause_state", 32'(state_o), 32'd1);
        check("pause_cpu_rst", 32'(cpu_rst), 32'd0);
        check("pause_cpu_en", 32'(cpu_en), 32'd0);
        check("pause_count", cycle_count, 32'd0);
        cyc(3);

        // Run for 40 cycles: one pulse every 4 cycles, first 4 after entry.
        btn_run = 1'b1;
        cyc(5);
        check("run_not_yet", 32'(state_o), 32'd1);
        cyc(1);
        check("run_entry", 32'(state_o), 32'd2);
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (i == 4) btn_run = 1'b0;
            check("run_pulse", 32'(cpu_en), 32'((i % 4) == 0));
        end
        check("run_count", cycle_count, 32'd10);

        btn_run = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cyc(1);
            if (i == 4) btn_run = 1'b0;
            check("pause_pulse", 32'(cpu_en), 32'(i == 4));
        end
        check("paused_state", 32'(state_o), 32'd1);
        check("paused_count", cycle_count, 32'd11);
        cyc(10);
        check("paused_hold_count", cycle_count, 32'd11);
        check("paused_hold_en", 32'(cpu_en), 32'd0);

        // Three single steps.
        for (int k = 0; k < 3; k++) begin
            btn_step = 1'b1;
            cyc(4);
            btn_step = 1'b0;
            cyc(2);
            check("step_state", 32'(state_o), 32'd3);
            check("step_en_early", 32'(cpu_en), 32'd0);
            cyc(1);
            check("step_back", 32'(state_o), 32'd1);
            check("step_en", 32'(cpu_en), 32'd1);
            check("step_count", cycle_count, 32'(12 + k));
            cyc(1);
            check("step_en_off", 32'(cpu_en), 32'd0);
            cyc(12);
        end

        // Halt on a tick cycle.
        btn_run = 1'b1;
        cyc(6);
        check("run2_entry", 32'(state_o), 32'd2);
        for (int i = 1; i <= 7; i++) begin
            cyc(1);
            if (i == 4) btn_run = 1'b0;
            check("run2_pulse", 32'(cpu_en), 32'(i == 4));
        end
        halt_req = 1'b1;
        cyc(1);
        check("halt_state", 32'(state_o), 32'd4);
        check("halt_no_pulse", 32'(cpu_en), 32'd0);
        check("halt_count", cycle_count, 32'd15);

        btn_run = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (i == 4) btn_run = 1'b0;
            check("halt_run_en", 32'(cpu_en), 32'd0);
        end
        btn_step = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (i == 4) btn_step = 1'b0;
            check("halt_step_en", 32'(cpu_en), 32'd0);
        end
        check("halt_stays", 32'(state_o), 32'd4);
        check("halt_count2", cycle_count, 32'd15);

        // CPU reset button leaves halt.
        btn_cpu_rst = 1'b1;
        halt_req = 1'b0;
        cyc(4);
        btn_cpu_rst = 1'b0;
        cyc(1);
        check("crst_not_yet", 32'(state_o), 32'd4);
        cyc(1);
        check("crst_state", 32'(state_o), 32'd0);
        check("crst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("crst_count", cycle_count, 32'd0);
        check("crst_cpu_en", 32'(cpu_en), 32'd0);
        cyc(1);
        check("crst_hold", 32'(cpu_rst), 32'd1);
        cyc(1);
        check("crst_pause", 32'(state_o), 32'd1);
        check("crst_release", 32'(cpu_rst), 32'd0);
        cyc(10);

        // Bouncing run button is rejected.
        for (int i = 0; i < 8; i++) begin
            btn_run = (i % 2) == 0;
            cyc(1);
        end
        btn_run = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            check("bounce_en", 32'(cpu_en), 32'd0);
        end
        check("bounce_state", 32'(state_o), 32'd1);
        check("bounce_count", cycle_count, 32'd0);

        // Run and step together: run wins.
        btn_run = 1'b1;
        btn_step = 1'b1;
        cyc(4);
        btn_run = 1'b0;
        btn_step = 1'b0;
        cyc(2);
        check("both_state", 32'(state_o), 32'd2);
        cyc(4);
        check("both_pulse", 32'(cpu_en), 32'd1);
        check("both_count", cycle_count, 32'd1);

        cyc(1);
        pc = 32'h0000_0010;
        bp_addr = 16'h0010;
        bp_valid = 1'b1;
        cyc(3);
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        check("bp_state", 32'(state_o), 32'd1);
        check("bp_no_pulse", 32'(cpu_en), 32'd0);
        check("bp_count", cycle_count, 32'd1);
        btn_run = 1'b1;
        cyc(4);
        btn_run = 1'b0;
        cyc(2);
        check("bp_resume", 32'(state_o), 32'd2);
        cyc(4);
        check("bp_skip_pulse", 32'(cpu_en), 32'd1);
        check("bp_skip_count", cycle_count, 32'd2);
        cyc(4);
        check("bp_again_state", 32'(state_o), 32'd1);
        check("bp_again_en", 32'(cpu_en), 32'd0);
        check("bp_again_count", cycle_count, 32'd2);
`else
        check("nobp_state", 32'(state_o), 32'd2);
        check("nobp_pulse", 32'(cpu_en), 32'd1);
        check("nobp_count", cycle_count, 32'd2);
        btn_run = 1'b1;
        cyc(4);
        btn_run = 1'b0;
        cyc(2);
        check("nobp_pause", 32'(state_o), 32'd1);
        check("nobp_count2", cycle_count, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
